vx_dram_sched: RTL and testbench
================================

VX_DRAM_SCHED -- requirements
Module: VX_dram_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, line width in bits; BYTEEN width is DATA_WIDTH/8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26, line address width.
REQ-004 SHALL have parameter TAG_IN_WIDTH, default 8, requester tag width; TAG_OUT_WIDTH is TAG_IN_WIDTH+LOG2UP(NUM_REQS).
REQ-005 SHALL have parameter MAX_PENDING, default 8, maximum outstanding reads per requester (power of 2).
REQ-006 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid_in / req_rw_in / req_ready_in  input/input/output  NUM_REQS  per-requester request handshake and write flag.
- req_byteen_in / req_addr_in / req_data_in / req_tag_in  input  NUM_REQS x (BYTEEN / ADDR / DATA / TAG_IN)  per-requester request payload.
- req_valid_out / req_rw_out / req_ready_out  output/output/input  1  merged DRAM request handshake.
- req_byteen_out / req_addr_out / req_data_out / req_tag_out  output  BYTEEN / ADDR / DATA / TAG_OUT  merged payload.
- rsp_valid_in / rsp_ready_in  input/output  1  DRAM response handshake.
- rsp_data_in / rsp_tag_in  input  DATA / TAG_OUT  DRAM response payload.
- rsp_valid_out / rsp_ready_out  output/input  NUM_REQS  per-requester response handshake.
- rsp_data_out / rsp_tag_out  output  DATA / TAG_IN  broadcast response payload.
- tag_err  output  1  sticky flag: response for an unknown or idle requester.

Function
REQ-007 SHALL treat requester i as eligible when req_valid_in[i] is high and either req_rw_in[i] is high or pending[i] < MAX_PENDING.
REQ-008 SHALL grant one eligible requester per cycle, round-robin starting at pointer ptr; after a grant to requester k, ptr SHALL become (k+1) mod NUM_REQS, and it is unchanged when there is no grant.
REQ-009 SHALL hold the request in a one-entry output register; req_ready_in[k] SHALL be high only for the granted k, and only when the register is empty or is firing this cycle.
REQ-010 SHALL present an accepted request on req_*_out exactly 1 cycle after the input fire, held stable until req_valid_out && req_ready_out.
REQ-011 SHALL form req_tag_out as {req_tag_in[k], k}, with the requester index in the LSBs.
REQ-012 SHALL increment pending[k] when a read request is accepted, and decrement pending[j] when a response fires to requester j; if both happen in the same cycle, pending SHALL stay unchanged. Writes SHALL NOT count.
REQ-013 SHALL route responses combinationally: j = rsp_tag_in LSBs; rsp_valid_out[j] = rsp_valid_in; rsp_ready_in = rsp_ready_out[j]; rsp_tag_out = rsp_tag_in upper bits.
REQ-014 SHALL, if j >= NUM_REQS or pending[j] == 0, assert rsp_ready_in, drive no rsp_valid_out, discard the response, and set tag_err.
REQ-015 SHALL, when NUM_REQS == 1, bypass arbitration, add no index bits, and keep the output register.

Reset
REQ-016 SHALL, while reset is low, asynchronously clear: ptr=0; all pending=0; output register empty; req_valid_out=0; tag_err=0. All other outputs SHALL be 0 or don't-care.
REQ-017 SHALL discard any in-flight request held in the output register when reset is asserted mid-operation, and SHALL NOT grant anything in the first cycle after reset deasserts.

Configuration
REQ-018 SHALL, with DRAM_SCHED_PERF_EN defined, add an output perf_stalls (64 bits) that counts cycles where req_valid_out && !req_ready_out, plus an output perf_credit_stalls (64 bits) that counts cycles where a read is blocked only by MAX_PENDING; both are cleared by reset and wrap on overflow.
REQ-019 SHALL, without DRAM_SCHED_PERF_EN, omit both ports and both counters.

Verification
REQ-020 Requesters 0..3 all issue reads continuously, DRAM always ready -> grants occur in order 0,1,2,3,0; req_tag_out LSBs = 0,1,2,3,0; one output per cycle after a 1-cycle fill.
REQ-021 Requester 2 issues 8 reads with no responses (MAX_PENDING=8) -> 9th read stalls while requesters 0/1/3 continue; one response with tag LSB 2 -> 9th read accepted the following cycle.
REQ-022 req_ready_out held low 5 cycles with requester 1 valid -> req_*_out stable 5 cycles, req_ready_in[1] low after the first accept, no lost or duplicated request.
REQ-023 Response tag {8'hA5, 2'd3} with rsp_ready_out[3]=0 -> rsp_valid_out=4'b1000, rsp_ready_in=0, rsp_tag_out=8'hA5; raise rsp_ready_out[3] -> fire, pending[3] decrements.
REQ-024 Response to requester 1 with pending[1]=0 -> rsp_ready_in=1, rsp_valid_out=0, tag_err=1 and remains 1 until reset.
REQ-025 Assert reset while the output register is full and pending[0]=3 -> req_valid_out=0 immediately, pending cleared, first grant occurs at the second cycle after release.

Source files
------------

// File: rtl/vx_dram_sched.sv
// ---------------------------------------------------------------------------
// vx_dram_sched
//   Merges NUM_REQS requester ports onto one DRAM request port and routes
//   DRAM responses back to the requester encoded in the response tag.
//
//   Arbitration is round-robin from ptr over the eligible requesters. A read
//   is eligible only while its requester has fewer than MAX_PENDING reads
//   outstanding; writes are always eligible. The winner is captured in a
//   one-entry output register, so a request appears on req_*_out one cycle
//   after it is accepted. The requester index goes into the LSBs of
//   req_tag_out. When NUM_REQS == 1 there is no index field.
//
//   Responses are routed combinationally by the tag LSBs. A response whose
//   index is out of range, or whose requester has no read outstanding, is
//   accepted and dropped, and sets the sticky tag_err flag.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   req_*_in  [NUM_REQS]    per-requester request channel; payload buses are
//                           flattened, requester i in slice i
//   req_*_out               merged DRAM request channel
//   rsp_*_in                DRAM response channel
//   rsp_valid_out/ready_out per-requester response handshake
//   rsp_data_out/tag_out    response payload, broadcast to all requesters
//   tag_err                 sticky: a response could not be routed
//   perf_stalls, perf_credit_stalls   only with DRAM_SCHED_PERF_EN defined
//
// Handshake rule, all channels: a transfer happens on a rising edge where
// valid and ready are both high. A producer keeps valid and payload stable
// until that edge. req_ready_in and rsp_ready_in depend on the
// corresponding valid inputs (they name the granted or addressed requester).
//
// Optional feature macro: DRAM_SCHED_PERF_EN adds the two 64-bit counters.
// ---------------------------------------------------------------------------
module vx_dram_sched #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int MAX_PENDING   = 8,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int REQ_SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + REQ_SEL_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic                             req_valid_out,
  output logic                             req_rw_out,
  input  logic                             req_ready_out,
  output logic [BYTEEN_WIDTH-1:0]          req_byteen_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             rsp_valid_in,
  output logic                             rsp_ready_in,
  input  logic [DATA_WIDTH-1:0]            rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
  output logic [NUM_REQS-1:0]              rsp_valid_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_out,
  output logic [DATA_WIDTH-1:0]            rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
  output logic                             tag_err
`ifdef DRAM_SCHED_PERF_EN
  ,
  output logic [63:0]                      perf_stalls,
  output logic [63:0]                      perf_credit_stalls
`endif
);

  localparam int SEL_W = (REQ_SEL_BITS > 0) ? REQ_SEL_BITS : 1;
  localparam int CNT_W = $clog2(MAX_PENDING) + 1;
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

  logic [SEL_W-1:0]         ptr;
  logic [CNT_W-1:0]         pending [NUM_REQS];
  // Low for the first cycle after reset release so nothing is granted then.
  logic                     started;

  logic [NUM_REQS-1:0]      eligible;
  logic                     grant_found;
  logic [SEL_W-1:0]         grant_idx;
  logic [SEL_W-1:0]         ptr_next;
  int                       arb_idx;
  logic                     out_free;
  logic                     accept;

  logic                     sel_rw;
  logic [BYTEEN_WIDTH-1:0]  sel_byteen;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [TAG_IN_WIDTH-1:0]  sel_tag_in;
  logic [TAG_OUT_WIDTH-1:0] sel_tag_out;

  logic [SEL_W-1:0]         rsp_idx;
  logic                     rsp_idx_ok;
  logic                     rsp_pend_nz;
  logic                     rsp_rdy_sel;
  logic                     rsp_bad;
  logic [NUM_REQS-1:0]      rsp_fire;

  // ---------------- arbitration ----------------
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pending[i] < PEND_MAX));
    end
  end

  // First eligible requester scanning upward from ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    for (int off = 0; off < NUM_REQS; off++) begin
      arb_idx = (int'(ptr) + off) % NUM_REQS;
      if (!grant_found && eligible[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(arb_idx);
      end
    end
  end

  assign ptr_next = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
  assign out_free = !req_valid_out || req_ready_out;
  assign accept   = started && grant_found && out_free;

  always_comb begin
    req_ready_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready_in[i] = accept && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    sel_rw     = 1'b0;
    sel_byteen = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_tag_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_rw     = req_rw_in[i];
        sel_byteen = req_byteen_in[i*BYTEEN_WIDTH +: BYTEEN_WIDTH];
        sel_addr   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag_in = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
  end

  // Requester index lives in the tag LSBs; no index field for one requester.
  if (REQ_SEL_BITS > 0) begin : g_idx
    assign sel_tag_out = {sel_tag_in, grant_idx};
    assign rsp_idx     = rsp_tag_in[REQ_SEL_BITS-1:0];
    assign rsp_tag_out = rsp_tag_in[TAG_OUT_WIDTH-1:REQ_SEL_BITS];
  end else begin : g_noidx
    assign sel_tag_out = sel_tag_in;
    assign rsp_idx     = '0;
    assign rsp_tag_out = rsp_tag_in;
  end

  // ---------------- response routing ----------------
  always_comb begin
    rsp_idx_ok  = 1'b0;
    rsp_pend_nz = 1'b0;
    rsp_rdy_sel = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == SEL_W'(i)) begin
        rsp_idx_ok  = 1'b1;
        rsp_pend_nz = (pending[i] != '0);
        rsp_rdy_sel = rsp_ready_out[i];
      end
    end
  end

  // An unroutable response is swallowed so it cannot block the DRAM side.
  assign rsp_bad      = !(rsp_idx_ok && rsp_pend_nz);
  assign rsp_ready_in = rsp_bad ? 1'b1 : rsp_rdy_sel;
  assign rsp_data_out = rsp_data_in;

  always_comb begin
    rsp_valid_out = '0;
    rsp_fire      = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_valid_out[i] = rsp_valid_in && !rsp_bad && (rsp_idx == SEL_W'(i));
      rsp_fire[i]      = rsp_valid_out[i] && rsp_ready_out[i];
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      started        <= 1'b0;
      req_valid_out  <= 1'b0;
      req_rw_out     <= 1'b0;
      req_byteen_out <= '0;
      req_addr_out   <= '0;
      req_data_out   <= '0;
      req_tag_out    <= '0;
      tag_err        <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        ptr            <= ptr_next;
        req_valid_out  <= 1'b1;
        req_rw_out     <= sel_rw;
        req_byteen_out <= sel_byteen;
        req_addr_out   <= sel_addr;
        req_data_out   <= sel_data;
        req_tag_out    <= sel_tag_out;
      end else if (req_valid_out && req_ready_out) begin
        req_valid_out <= 1'b0;
      end
      // Simultaneous read accept and response fire for one requester cancel.
      for (int i = 0; i < NUM_REQS; i++) begin
        if (accept && !sel_rw && (grant_idx == SEL_W'(i)) && !rsp_fire[i]) begin
          pending[i] <= pending[i] + 1'b1;
        end else if (rsp_fire[i] && !(accept && !sel_rw && (grant_idx == SEL_W'(i)))) begin
          pending[i] <= pending[i] - 1'b1;
        end
      end
      if (rsp_valid_in && rsp_bad) tag_err <= 1'b1;
    end
  end

`ifdef DRAM_SCHED_PERF_EN
  logic credit_blocked;

  // A read waiting only because its requester is at the outstanding limit.
  always_comb begin
    credit_blocked = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (req_valid_in[i] && !req_rw_in[i] && (pending[i] >= PEND_MAX)) credit_blocked = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls        <= '0;
      perf_credit_stalls <= '0;
    end else begin
      if (req_valid_out && !req_ready_out) perf_stalls <= perf_stalls + 64'd1;
      if (credit_blocked) perf_credit_stalls <= perf_credit_stalls + 64'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_vx_dram_sched.sv
// Bench for vx_dram_sched: directed scenarios plus a randomized phase, all
// checked against a transaction-level model (eligibility and round-robin
// arithmetic, per-requester outstanding counts, expected-output queue).
module tb_vx_dram_sched;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int MP  = 8;
  localparam int BW  = DW / 8;
  localparam int TOW = TW + 2;
  localparam int PW  = 1 + BW + AW + DW + TOW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid_in = '0, req_rw_in = '0, req_ready_in;
  logic [N*BW-1:0] req_byteen_in = '0;
  logic [N*AW-1:0] req_addr_in = '0;
  logic [N*DW-1:0] req_data_in = '0;
  logic [N*TW-1:0] req_tag_in = '0;
  logic            req_valid_out, req_rw_out;
  logic            req_ready_out = 1'b1;
  logic [BW-1:0]   req_byteen_out;
  logic [AW-1:0]   req_addr_out;
  logic [DW-1:0]   req_data_out;
  logic [TOW-1:0]  req_tag_out;
  logic            rsp_valid_in = 1'b0, rsp_ready_in;
  logic [DW-1:0]   rsp_data_in = '0;
  logic [TOW-1:0]  rsp_tag_in = '0;
  logic [N-1:0]    rsp_valid_out;
  logic [N-1:0]    rsp_ready_out = '1;
  logic [DW-1:0]   rsp_data_out;
  logic [TW-1:0]   rsp_tag_out;
  logic            tag_err;
`ifdef DRAM_SCHED_PERF_EN
  logic [63:0]     perf_stalls, perf_credit_stalls;
`endif

  always #5 clk = ~clk;

  vx_dram_sched #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_ready_in(req_ready_in),
    .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in),
    .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_ready_out(req_ready_out),
    .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out),
    .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .rsp_valid_in(rsp_valid_in), .rsp_ready_in(rsp_ready_in),
    .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_out(rsp_ready_out),
    .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .tag_err(tag_err)
`ifdef DRAM_SCHED_PERF_EN
    , .perf_stalls(perf_stalls), .perf_credit_stalls(perf_credit_stalls)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int              total = 0;
  int              bad = 0;
  logic [PW-1:0]   exp_q[$];
  int              m_ptr;
  int              m_pend[N];
  bit              m_started;
  bit              m_err;
  longint          m_stalls;
  longint          m_credit;
  int              dut_grant_cnt[N];
  int              out_lsb_log[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_started = 1'b0;
    m_err = 1'b0;
    m_stalls = 0;
    m_credit = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input int i, input bit v, input bit rw);
    req_valid_in[i] = v;
    req_rw_in[i] = rw;
    req_byteen_in[i*BW +: BW] = BW'($urandom);
    req_addr_in[i*AW +: AW] = AW'($urandom);
    req_data_in[i*DW +: DW] = $urandom;
    req_tag_in[i*TW +: TW] = TW'($urandom);
  endtask

  task automatic drive_rsp_idx(input bit v, input int j);
    rsp_valid_in = v;
    rsp_tag_in = TOW'($urandom_range(0, 255) * N + j);
    rsp_data_in = $urandom;
  endtask

  task automatic set_idle();
    req_valid_in = '0;
    req_rw_in = '0;
    req_ready_out = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_ready_out = '1;
  endtask

  // One clock cycle: inputs were driven at the preceding negedge. Compare
  // the DUT against the model, advance the model, end at the next negedge.
  task automatic step();
    int k, j, tv;
    bit found, rbad, rfire, credit, stall;
    logic [N-1:0] exp_rdy;
    #1;
    if (exp_q.size() > 0) begin
      check("out_valid", req_valid_out, 1);
      check("out_payload", {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out}, exp_q[0]);
    end else begin
      check("out_valid", req_valid_out, 0);
    end

    found = 1'b0;
    k = 0;
    if (m_started && (exp_q.size() == 0 || req_ready_out)) begin
      for (int o = 0; o < N; o++) begin
        int i;
        i = (m_ptr + o) % N;
        if (!found && req_valid_in[i] && (req_rw_in[i] || m_pend[i] < MP)) begin
          found = 1'b1;
          k = i;
        end
      end
    end
    exp_rdy = found ? N'(1 << k) : '0;
    check("req_ready_in", req_ready_in, exp_rdy);

    j = int'(rsp_tag_in) % N;
    rbad = (m_pend[j] == 0);
    if (rsp_valid_in) begin
      check("rsp_valid_out", rsp_valid_out, rbad ? '0 : N'(1 << j));
      check("rsp_ready_in", rsp_ready_in, rbad ? 1'b1 : rsp_ready_out[j]);
      if (!rbad) begin
        check("rsp_tag_out", rsp_tag_out, rsp_tag_in / N);
        check("rsp_data_out", rsp_data_out, rsp_data_in);
      end
    end else begin
      check("rsp_valid_out_idle", rsp_valid_out, '0);
    end
    check("tag_err", tag_err, m_err);
`ifdef DRAM_SCHED_PERF_EN
    check("perf_stalls", perf_stalls, m_stalls);
    check("perf_credit_stalls", perf_credit_stalls, m_credit);
`endif

    // DUT-side observations used by directed scenarios
    for (int i = 0; i < N; i++) if (req_ready_in[i]) dut_grant_cnt[i]++;
    if (req_valid_out && req_ready_out) out_lsb_log.push_back(int'(req_tag_out[1:0]));

    // model advance
    stall = (exp_q.size() > 0) && !req_ready_out;
    credit = 1'b0;
    for (int i = 0; i < N; i++) if (req_valid_in[i] && !req_rw_in[i] && m_pend[i] >= MP) credit = 1'b1;
    rfire = rsp_valid_in && !rbad && rsp_ready_out[j];
    if (exp_q.size() > 0 && req_ready_out) void'(exp_q.pop_front());
    if (found) begin
      tv = int'(req_tag_in[k*TW +: TW]) * N + k;
      exp_q.push_back({req_rw_in[k], req_byteen_in[k*BW +: BW], req_addr_in[k*AW +: AW],
                       req_data_in[k*DW +: DW], TOW'(tv)});
      if (!req_rw_in[k]) m_pend[k]++;
      m_ptr = (k + 1) % N;
    end
    if (rfire) m_pend[j]--;
    if (rsp_valid_in && rbad) m_err = 1'b1;
    if (stall) m_stalls++;
    if (credit) m_credit++;
    m_started = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Return every outstanding read and empty the output register.
  task automatic drain();
    set_idle();
    step();
    for (int j = 0; j < N; j++) begin
      while (m_pend[j] > 0) begin
        drive_rsp_idx(1'b1, j);
        step();
      end
    end
    rsp_valid_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g0, f0, rj;
    bit rv;
    model_reset();
    foreach (dut_grant_cnt[i]) dut_grant_cnt[i] = 0;

    // reset state, with requests already pending
    req_valid_in = '1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid_out", req_valid_out, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_ready_in", req_ready_in, '0);
    @(negedge clk);
    reset = 1'b1;

    // all four requesters read continuously, DRAM always ready
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0);
      step();
    end
    check("rr_out_count", out_lsb_log.size(), 10);
    check("rr_order0", out_lsb_log[0], 0);
    check("rr_order1", out_lsb_log[1], 1);
    check("rr_order2", out_lsb_log[2], 2);
    check("rr_order3", out_lsb_log[3], 3);
    check("rr_order4", out_lsb_log[4], 0);
    drain();

    // requester 2 reads up to the outstanding limit while others write
    foreach (dut_grant_cnt[i]) dut_grant_cnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      drive_req(0, 1'b1, 1'b1);
      drive_req(1, 1'b1, 1'b1);
      drive_req(2, 1'b1, 1'b0);
      drive_req(3, 1'b1, 1'b1);
      step();
    end
    check("credit_r2_grants", dut_grant_cnt[2], 8);
    check("credit_others", dut_grant_cnt[0] + dut_grant_cnt[1] + dut_grant_cnt[3], 32);
    drive_req(0, 1'b1, 1'b1);
    drive_req(1, 1'b1, 1'b1);
    drive_req(2, 1'b1, 1'b0);
    drive_req(3, 1'b1, 1'b1);
    drive_rsp_idx(1'b1, 2);
    step();
    check("credit_still_blocked", dut_grant_cnt[2], 8);
    rsp_valid_in = 1'b0;
    req_valid_in = 4'b0100;
    step();
    check("credit_released", dut_grant_cnt[2], 9);
    drain();

    // DRAM back-pressure for several cycles with requester 1 valid
    f0 = out_lsb_log.size();
    g0 = dut_grant_cnt[1];
    req_ready_out = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_req(1, 1'b1, 1'b0);
      step();
    end
    check("bp_single_accept", dut_grant_cnt[1] - g0, 1);
    req_valid_in = '0;
    req_ready_out = 1'b1;
    step();
    check("bp_one_output", out_lsb_log.size() - f0, 1);
    check("bp_output_idx", out_lsb_log[out_lsb_log.size() - 1], 1);
    drain();

    // response to requester 3 held by the requester, then accepted
    drive_req(3, 1'b1, 1'b0);
    step();
    set_idle();
    step();
    rsp_valid_in = 1'b1;
    rsp_tag_in = {8'hA5, 2'd3};
    rsp_data_in = $urandom;
    rsp_ready_out = 4'b0111;
    step();
    #1;
    check("rsp3_valid_out", rsp_valid_out, 4'b1000);
    check("rsp3_ready_in", rsp_ready_in, 0);
    check("rsp3_tag_out", rsp_tag_out, 8'hA5);
    rsp_ready_out = 4'b1111;
    step();
    #1;
    check("rsp3_after_fire_valid", rsp_valid_out, '0);
    check("rsp3_after_fire_ready", rsp_ready_in, 1);
    rsp_valid_in = 1'b0;
    step();

    // response to an idle requester
    drive_rsp_idx(1'b1, 1);
    rsp_ready_out = '0;
    #1;
    check("err_ready_in", rsp_ready_in, 1);
    check("err_valid_out", rsp_valid_out, '0);
    step();
    check("err_set", tag_err, 1);
    set_idle();
    repeat (3) step();
    check("err_sticky", tag_err, 1);

    // reset while the output register is full and requester 0 has 3 reads out
    req_ready_out = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_req(0, 1'b1, 1'b0);
      step();
    end
    req_valid_in = '0;
    req_ready_out = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("midrst_valid_out", req_valid_out, 0);
    check("midrst_tag_err", tag_err, 0);
    check("midrst_ready_in", req_ready_in, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_ready_out = 1'b1;
    g0 = dut_grant_cnt[0] + dut_grant_cnt[1] + dut_grant_cnt[2] + dut_grant_cnt[3];
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0);
    step();
    check("midrst_no_grant", dut_grant_cnt[0] + dut_grant_cnt[1] + dut_grant_cnt[2] + dut_grant_cnt[3] - g0, 0);
    f0 = dut_grant_cnt[0];
    step();
    check("midrst_first_grant", dut_grant_cnt[0] - f0, 1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) drive_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      req_ready_out = ($urandom_range(0, 3) != 0);
      rj = $urandom_range(0, N - 1);
      rv = (m_pend[rj] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      drive_rsp_idx(rv, rj);
      rsp_ready_out = N'($urandom) | N'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
